adc_readout_sequencer: RTL and testbench
========================================

// Module: adc_readout_sequencer
// PURPOSE
//  Sequences frame readout of the thermal sensor through the dual-channel ADC capture path.
//  Gates the ADC clock, waits for sensor settling and pairs each two-channel ADC sample into
//  even/odd column pixels. Emits pixels on a valid/ready stream with row/column tags.
//  Sits between the dual-lane ADC deserializer (upstream) and the frame buffer writer (downstream).
// PARAMETERS
//  ADC_WIDTH   14   sample width per channel
//  COLS        160  pixels per row; must be even (ch1 -> even column, ch2 -> odd column)
//  ROWS        120  rows per frame
//  SETTLE_CYC  8    CLK cycles with ADC_ENABLE=1 before the first sample of each row is accepted
//  ROW_GAP     4    CLK cycles with ADC_ENABLE=0 between rows
// PORTS
//  CLK           in   1          system clock
//  RESET         in   1          synchronous, active-high
//  START         in   1          frame start request; sampled only in IDLE
//  ABORT         in   1          abandon frame; overrides everything except RESET
//  SAMPLE_VALID  in   1          1-cycle pulse, SAMPLE1/SAMPLE2 valid (already in CLK domain)
//  SAMPLE1       in   ADC_WIDTH  channel-1 sample
//  SAMPLE2       in   ADC_WIDTH  channel-2 sample
//  PIX_READY     in   1          downstream accepts pixel
//  ADC_ENABLE    out  1          ADC clock gate enable
//  PIX_VALID     out  1          pixel valid
//  PIX_DATA      out  ADC_WIDTH  pixel value
//  PIX_ROW       out  clog2(ROWS) row of current pixel
//  PIX_COL       out  clog2(COLS) column of current pixel
//  BUSY          out  1          1 in any state except IDLE
//  FRAME_DONE    out  1          1-cycle pulse after last pixel of frame accepted
//  OVERRUN       out  1          sticky: a sample arrived while not in ACQ after first settle
// BEHAVIOUR
//  - Reset: state=IDLE; ADC_ENABLE, PIX_VALID, BUSY, FRAME_DONE, OVERRUN = 0; PIX_DATA/ROW/COL = 0.
//  - All outputs registered. States: IDLE, SETTLE, ACQ, OUT1, OUT2, GAP, DONE.
//  - IDLE: START=1 -> SETTLE; row=0, col=0, settle counter=0, OVERRUN cleared. START elsewhere ignored.
//  - SETTLE: ADC_ENABLE=1; SAMPLE_VALID ignored (no OVERRUN); after SETTLE_CYC cycles -> ACQ.
//  - ACQ: ADC_ENABLE=1; on SAMPLE_VALID latch SAMPLE1/SAMPLE2 -> OUT1 (next cycle PIX_VALID=1).
//  - OUT1: PIX_DATA=ch1, PIX_COL=col; PIX_VALID held until PIX_READY; on PIX_READY -> OUT2.
//  - OUT2: PIX_DATA=ch2, PIX_COL=col+1; on PIX_READY:
//      col+2<COLS -> col+=2, ACQ;  col+2==COLS and row<ROWS-1 -> row++, col=0, GAP;  else DONE.
//  - PIX_DATA/ROW/COL stable while PIX_VALID=1 and PIX_READY=0 (no change until accepted).
//  - SAMPLE_VALID in OUT1/OUT2: sample dropped, OVERRUN<=1 (sticky until next START or RESET).
//  - GAP: ADC_ENABLE=0 for ROW_GAP cycles -> SETTLE (settle counter reset).
//  - DONE: FRAME_DONE=1 for exactly one cycle, ADC_ENABLE=0 -> IDLE.
//  - ABORT in any non-IDLE state: next cycle IDLE, PIX_VALID=0, ADC_ENABLE=0, no FRAME_DONE;
//    OVERRUN retained. ABORT and START together in IDLE: stay IDLE.
//  - Counters never wrap: col max COLS-2 at pair start, row max ROWS-1.
//  - Latency: SAMPLE_VALID in ACQ at cycle n -> PIX_VALID=1 at n+1 (ch1), ch2 one cycle after ch1 accepted.
// TESTING (COLS=4, ROWS=2, SETTLE_CYC=3, ROW_GAP=2, PIX_READY=1 unless noted)
//  - RESET mid-frame -> next cycle all outputs 0, BUSY=0; START then runs a clean frame.
//  - START, SAMPLE_VALID pulses (0x0011,0x0022),(0x0033,0x0044) per row -> 8 pixels in order
//    (r0c0=0x11,r0c1=0x22,r0c2=0x33,r0c3=0x44,...); 2 ADC_ENABLE=0 cycles between rows; FRAME_DONE once.
//  - SAMPLE_VALID during SETTLE cycle 2 -> ignored, no pixel, OVERRUN=0; first pixel from next ACQ sample.
//  - PIX_READY=0 for 5 cycles on r0c1 -> PIX_VALID/DATA/COL held; SAMPLE_VALID meanwhile -> OVERRUN=1, dropped.
//  - ABORT while PIX_VALID=1 on r1c2 -> next cycle IDLE, PIX_VALID=0, ADC_ENABLE=0, FRAME_DONE never 1.
//  - START asserted while BUSY -> ignored; frame completes with 8 pixels, then IDLE.

Source files
------------

// File: rtl/adc_readout_sequencer.sv
// Frame readout sequencer: gates the ADC clock, waits out sensor settling and turns each
// dual-channel ADC sample into an even/odd column pixel pair on a valid/ready stream.
module adc_readout_sequencer #(
    parameter int unsigned ADC_WIDTH  = 14,
    parameter int unsigned COLS       = 160,
    parameter int unsigned ROWS       = 120,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned ROW_GAP    = 4,
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic                 SAMPLE_VALID,
    input  logic [ADC_WIDTH-1:0] SAMPLE1,
    input  logic [ADC_WIDTH-1:0] SAMPLE2,
    input  logic                 PIX_READY,
    output logic                 ADC_ENABLE,
    output logic                 PIX_VALID,
    output logic [ADC_WIDTH-1:0] PIX_DATA,
    output logic [ROW_W-1:0]     PIX_ROW,
    output logic [COL_W-1:0]     PIX_COL,
    output logic                 BUSY,
    output logic                 FRAME_DONE,
    output logic                 OVERRUN
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > ROW_GAP) ? SETTLE_CYC : ROW_GAP;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [COL_W-1:0] COL_LAST    = COL_W'(COLS - 2);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(ROW_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ACQ,
        OUT1,
        OUT2,
        GAP,
        DONE
    } state_t;

    state_t               state_q, state_n;
    logic [ROW_W-1:0]     row_q, row_n;
    logic [COL_W-1:0]     col_q, col_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic [ADC_WIDTH-1:0] ch2_q, ch2_n;
    logic                 overrun_n;
    logic [ADC_WIDTH-1:0] data_n;
    logic [ROW_W-1:0]     prow_n;
    logic [COL_W-1:0]     pcol_n;

    always_comb begin
        state_n   = state_q;
        row_n     = row_q;
        col_n     = col_q;
        cnt_n     = cnt_q;
        ch2_n     = ch2_q;
        overrun_n = OVERRUN;
        data_n    = PIX_DATA;
        prow_n    = PIX_ROW;
        pcol_n    = PIX_COL;

        if (ABORT && state_q != IDLE) begin
            state_n = IDLE;
        end else begin
            // Any sample outside ACQ once the first settle is over is lost data.
            if (SAMPLE_VALID && (state_q == OUT1 || state_q == OUT2 ||
                                 state_q == GAP  || state_q == DONE)) begin
                overrun_n = 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (START && !ABORT) begin
                        state_n   = SETTLE;
                        row_n     = '0;
                        col_n     = '0;
                        cnt_n     = '0;
                        overrun_n = 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_n = ACQ;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                ACQ: begin
                    if (SAMPLE_VALID) begin
                        state_n = OUT1;
                        data_n  = SAMPLE1;
                        ch2_n   = SAMPLE2;
                        prow_n  = row_q;
                        pcol_n  = col_q;
                    end
                end
                OUT1: begin
                    if (PIX_READY) begin
                        state_n = OUT2;
                        data_n  = ch2_q;
                        pcol_n  = col_q + COL_W'(1);
                    end
                end
                OUT2: begin
                    if (PIX_READY) begin
                        if (col_q < COL_LAST) begin
                            state_n = ACQ;
                            col_n   = col_q + COL_W'(2);
                        end else if (row_q < ROW_LAST) begin
                            state_n = GAP;
                            row_n   = row_q + ROW_W'(1);
                            col_n   = '0;
                            cnt_n   = '0;
                        end else begin
                            state_n = DONE;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_n = SETTLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            ch2_q      <= '0;
            ADC_ENABLE <= 1'b0;
            PIX_VALID  <= 1'b0;
            PIX_DATA   <= '0;
            PIX_ROW    <= '0;
            PIX_COL    <= '0;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            state_q    <= state_n;
            row_q      <= row_n;
            col_q      <= col_n;
            cnt_q      <= cnt_n;
            ch2_q      <= ch2_n;
            ADC_ENABLE <= (state_n == SETTLE) || (state_n == ACQ) ||
                          (state_n == OUT1)   || (state_n == OUT2);
            PIX_VALID  <= (state_n == OUT1) || (state_n == OUT2);
            PIX_DATA   <= data_n;
            PIX_ROW    <= prow_n;
            PIX_COL    <= pcol_n;
            BUSY       <= (state_n != IDLE);
            FRAME_DONE <= (state_n == DONE);
            OVERRUN    <= overrun_n;
        end
    end

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Directed bench for adc_readout_sequencer with a 4x2 frame, 3-cycle settle and 2-cycle row gap.
module tb_adc_readout_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        sample_valid;
    logic [13:0] sample1;
    logic [13:0] sample2;
    logic        pix_ready;
    logic        adc_enable;
    logic        pix_valid;
    logic [13:0] pix_data;
    logic [0:0]  pix_row;
    logic [1:0]  pix_col;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    adc_readout_sequencer #(
        .ADC_WIDTH (14),
        .COLS      (4),
        .ROWS      (2),
        .SETTLE_CYC(3),
        .ROW_GAP   (2)
    ) dut (
        .CLK         (clk),
        .RESET       (reset),
        .START       (start),
        .ABORT       (abort),
        .SAMPLE_VALID(sample_valid),
        .SAMPLE1     (sample1),
        .SAMPLE2     (sample2),
        .PIX_READY   (pix_ready),
        .ADC_ENABLE  (adc_enable),
        .PIX_VALID   (pix_valid),
        .PIX_DATA    (pix_data),
        .PIX_ROW     (pix_row),
        .PIX_COL     (pix_col),
        .BUSY        (busy),
        .FRAME_DONE  (frame_done),
        .OVERRUN     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Caller must be in ACQ; leaves the DUT one cycle after the ch2 pixel is accepted.
    task automatic do_pair(input logic [13:0] a, input logic [13:0] b,
                           input int unsigned r, input int unsigned c);
        sample1      = a;
        sample2      = b;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample1      = '0;
        sample2      = '0;
        chk($sformatf("r%0dc%0d_valid", r, c), pix_valid, 1);
        chk($sformatf("r%0dc%0d_data", r, c), pix_data, a);
        chk($sformatf("r%0dc%0d_row", r, c), pix_row, r);
        chk($sformatf("r%0dc%0d_col", r, c), pix_col, c);
        tick();
        chk($sformatf("r%0dc%0d_valid", r, c + 1), pix_valid, 1);
        chk($sformatf("r%0dc%0d_data", r, c + 1), pix_data, b);
        chk($sformatf("r%0dc%0d_row", r, c + 1), pix_row, r);
        chk($sformatf("r%0dc%0d_col", r, c + 1), pix_col, c + 1);
        tick();
    endtask

    task automatic settle_to_acq();
        for (int i = 0; i < 3; i++) begin
            chk("settle_en", adc_enable, 1);
            chk("settle_pv", pix_valid, 0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        sample1 = '0; sample2 = '0; pix_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_en", adc_enable, 0);
        chk("rst_pv", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_row", pix_row, 0);
        chk("rst_col", pix_col, 0);

        // Reset while a pixel is pending
        start = 1'b1; tick(); start = 1'b0;
        chk("s0_busy", busy, 1);
        settle_to_acq();
        sample1 = 14'h1234; sample2 = 14'h0567; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("pre_rst_pv", pix_valid, 1);
        chk("pre_rst_data", pix_data, 14'h1234);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_pv", pix_valid, 0);
        chk("mid_rst_data", pix_data, 0);
        chk("mid_rst_en", adc_enable, 0);
        chk("mid_rst_busy", busy, 0);

        // ABORT with START in IDLE stays idle
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_en", adc_enable, 0);

        // Clean frame, stray sample in SETTLE, START while busy
        start = 1'b1; tick(); start = 1'b0;
        chk("f1_busy", busy, 1);
        chk("f1_en", adc_enable, 1);
        tick();
        sample1 = 14'h3FFF; sample2 = 14'h3FFF; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("settle_smp_pv", pix_valid, 0);
        chk("settle_smp_ovr", overrun, 0);
        tick();
        do_pair(14'h0011, 14'h0022, 0, 0);
        chk("f1_acq_pv", pix_valid, 0);
        chk("f1_acq_en", adc_enable, 1);
        start = 1'b1;
        do_pair(14'h0033, 14'h0044, 0, 2);
        chk("gap1_en", adc_enable, 0);
        chk("gap1_busy", busy, 1);
        tick();
        chk("gap2_en", adc_enable, 0);
        tick();
        settle_to_acq();
        do_pair(14'h0055, 14'h0066, 1, 0);
        start = 1'b0;
        do_pair(14'h0077, 14'h0088, 1, 2);
        chk("f1_done", frame_done, 1);
        chk("f1_done_en", adc_enable, 0);
        chk("f1_done_pv", pix_valid, 0);
        tick();
        chk("f1_done_pulse", frame_done, 0);
        chk("f1_idle_busy", busy, 0);
        chk("f1_ovr", overrun, 0);
        tick();
        chk("f1_stays_idle", busy, 0);

        // Backpressure with overrun, then ABORT on r1c2
        start = 1'b1; tick(); start = 1'b0;
        settle_to_acq();
        sample1 = 14'h00A1; sample2 = 14'h00A2; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("bp_c0_data", pix_data, 14'h00A1);
        tick();
        chk("bp_c1_data", pix_data, 14'h00A2);
        pix_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                sample1 = 14'h00BB; sample2 = 14'h00CC; sample_valid = 1'b1;
            end
            tick();
            sample_valid = 1'b0;
            chk("bp_hold_pv", pix_valid, 1);
            chk("bp_hold_data", pix_data, 14'h00A2);
            chk("bp_hold_col", pix_col, 1);
            chk("bp_hold_row", pix_row, 0);
        end
        chk("bp_ovr", overrun, 1);
        pix_ready = 1'b1;
        tick();
        chk("bp_release_pv", pix_valid, 0);
        do_pair(14'h00A3, 14'h00A4, 0, 2);
        tick();
        tick();
        settle_to_acq();
        do_pair(14'h00B1, 14'h00B2, 1, 0);
        sample1 = 14'h00B3; sample2 = 14'h00B4; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("ab_pv", pix_valid, 1);
        chk("ab_col", pix_col, 2);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_pv_after", pix_valid, 0);
        chk("ab_en_after", adc_enable, 0);
        chk("ab_busy_after", busy, 0);
        chk("ab_done_after", frame_done, 0);
        chk("ab_ovr_kept", overrun, 1);
        tick();
        chk("ab_done_later", frame_done, 0);
        chk("ab_idle", busy, 0);

        // START clears the sticky overrun
        start = 1'b1; tick(); start = 1'b0;
        chk("start_clr_ovr", overrun, 0);
        chk("start_busy", busy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
